// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types, constants and the load-use hazard helper.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Memory-wait FSM states. WAIT is only entered on a data access that missed.
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_t;

  // Register zero is hard-wired, so a load targeting it can never cause a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Forwarding-mux select encodings, shared with the EX-stage forwarding unit.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Bundle of pipeline register controls produced every cycle.
  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
    logic pipeStall;
  } ctrl_t;

  // Free-running pipeline: every register advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{
    pcWrite:    1'b1,
    ifidWrite:  1'b1,
    ifidFlush:  1'b0,
    idexBubble: 1'b0,
    pipeStall:  1'b0
  };

  // A load in EX whose result is needed by the instruction in ID cannot be
  // forwarded in time; the consumer has to wait one cycle.
  function automatic logic loadUse(
    input logic       memRead,
    input logic [4:0] wbAddr,
    input logic [4:0] rsAddr,
    input logic [4:0] rtAddr,
    input logic       useRt
  );
    return memRead && (wbAddr != REG_ZERO) &&
           ((wbAddr == rsAddr) || (useRt && (wbAddr == rtAddr)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// Latency: n/a (wires only).
// Backpressure: memory req is held by the datapath until ack; the controller stalls meanwhile.
// Ports: ID/EX hazard inputs, MEM req/ack handshake, pipeline control outputs,
//        stall counter and sticky error flags.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rsAddr_i;
  logic [4:0]       ID_rtAddr_i;
  logic             ID_useRt_i;
  logic             EX_memRead_i;
  logic [4:0]       EX_wbAddr_i;
  logic             ID_branchTaken_i;
  logic             MEM_memReq_i;
  logic             MEM_memAck_i;
  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IFID_flush_o;
  logic             IDEX_bubble_o;
  logic             pipe_stall_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             timeout_o;
  logic             proto_err_o;

  // Datapath side: supplies hazard information, consumes the controls.
  modport master (
    output ID_rsAddr_i, ID_rtAddr_i, ID_useRt_i, EX_memRead_i, EX_wbAddr_i,
           ID_branchTaken_i, MEM_memReq_i, MEM_memAck_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, pipe_stall_o,
           stall_cnt_o, timeout_o, proto_err_o
  );

  // Controller side.
  modport slave (
    input  ID_rsAddr_i, ID_rtAddr_i, ID_useRt_i, EX_memRead_i, EX_wbAddr_i,
           ID_branchTaken_i, MEM_memReq_i, MEM_memAck_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, pipe_stall_o,
           stall_cnt_o, timeout_o, proto_err_o
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
// Latency: count visible one cycle after inc_i/clr_i.
// Backpressure: none; clr_i wins over inc_i.
// Ports: clk_i, rst_i (async active-low), clr_i, inc_i, cnt_o[W-1:0].
module sat_counter #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != MAX)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use bubbles, data-memory wait stalls, branch flushes.
// Latency: controls are combinational (same cycle as the hazard); counters/flags update on the edge.
// Backpressure: a pending memory access freezes the whole pipe until ack; load-use holds PC and IF/ID.
// Ports: clk_i, rst_i (async active-low), bus (hazard_stall_ctrl_if.slave).
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hazard_stall_ctrl_if.slave    bus
);

  localparam int               WAIT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

  ctrl_state_t       state;
  logic              lu;
  logic              ms;
  ctrl_t             ctrl;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  stallCnt;
  logic              timeoutQ;
  logic              protoErrQ;

  assign lu = loadUse(bus.EX_memRead_i, bus.EX_wbAddr_i, bus.ID_rsAddr_i,
                      bus.ID_rtAddr_i, bus.ID_useRt_i);

  // A miss stalls from the very cycle the request appears; in WAIT the stall
  // releases in the ack cycle so the pipe advances on that edge.
  assign ms = ((state == RUN)  && bus.MEM_memReq_i && !bus.MEM_memAck_i) ||
              ((state == WAIT) && !bus.MEM_memAck_i);

  // Priority: memory stall > load-use > taken branch. A branch that coincides
  // with a bubble is simply re-evaluated next cycle when ID is re-presented.
  // Reset forces the free-running controls regardless of hazard inputs.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst_i) begin
      if (ms) begin
        ctrl.pcWrite   = 1'b0;
        ctrl.ifidWrite = 1'b0;
        ctrl.pipeStall = 1'b1;
      end else if (lu) begin
        ctrl.pcWrite    = 1'b0;
        ctrl.ifidWrite  = 1'b0;
        ctrl.idexBubble = 1'b1;
      end else if (bus.ID_branchTaken_i) begin
        ctrl.ifidFlush = 1'b1;
      end
    end
  end

  // FSM plus sticky error flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      timeoutQ  <= 1'b0;
      protoErrQ <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (bus.MEM_memReq_i && !bus.MEM_memAck_i) begin
          state <= WAIT;
        end
      end else begin
        if (bus.MEM_memAck_i) begin
          state <= RUN;
        end
      end
      // waitCnt counts stalled WAIT cycles starting at 1, so this fires at the
      // end of the TIMEOUT_CYC-th unacknowledged WAIT cycle.
      if ((state == WAIT) && !bus.MEM_memAck_i && (waitCnt == WAIT_MAX)) begin
        timeoutQ <= 1'b1;
      end
      if (bus.MEM_memAck_i && !bus.MEM_memReq_i) begin
        protoErrQ <= 1'b1;
      end
    end
  end

  // Counts consecutive memory-stall cycles; any non-stall cycle clears it, so
  // it reads 1 in the first WAIT cycle.
  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_MAX)
  ) u_waitCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!ms),
    .inc_i (ms),
    .cnt_o (waitCnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_stallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (!ctrl.pcWrite),
    .cnt_o (stallCnt)
  );

  assign bus.PC_write_o    = ctrl.pcWrite;
  assign bus.IFID_write_o  = ctrl.ifidWrite;
  assign bus.IFID_flush_o  = ctrl.ifidFlush;
  assign bus.IDEX_bubble_o = ctrl.idexBubble;
  assign bus.pipe_stall_o  = ctrl.pipeStall;
  assign bus.stall_cnt_o   = stallCnt;
  assign bus.timeout_o     = timeoutQ;
  assign bus.proto_err_o   = protoErrQ;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table plus hand-written multi-cycle sequences.
// Latency: controls checked mid-cycle, counters/flags checked just after the edge.
// Backpressure: n/a (bench drives every input directly).
module tb_hazard_stall_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl_if #(.CNT_W(32)) bus ();

  hazard_stall_ctrl #(
    .TIMEOUT_CYC (4),
    .CNT_W       (32)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // ctl = {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_stall}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_FLUSH = 5'b11100;
  localparam logic [4:0] C_LU    = 5'b00010;
  localparam logic [4:0] C_MS    = 5'b00001;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRt;
    logic       memRead;
    logic [4:0] wb;
    logic       br;
    logic       req;
    logic       ack;
    logic [4:0] ctl;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] ctl;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] expCnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctlNow();
    return {bus.PC_write_o, bus.IFID_write_o, bus.IFID_flush_o,
            bus.IDEX_bubble_o, bus.pipe_stall_o};
  endfunction

  function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                              input logic useRt, input logic memRead, input logic [4:0] wb,
                              input logic br, input logic req, input logic ack,
                              input logic [4:0] ctl);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.useRt = useRt; v.memRead = memRead;
    v.wb = wb; v.br = br; v.req = req; v.ack = ack; v.ctl = ctl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    bus.ID_rsAddr_i      = v.rs;
    bus.ID_rtAddr_i      = v.rt;
    bus.ID_useRt_i       = v.useRt;
    bus.EX_memRead_i     = v.memRead;
    bus.EX_wbAddr_i      = v.wb;
    bus.ID_branchTaken_i = v.br;
    bus.MEM_memReq_i     = v.req;
    bus.MEM_memAck_i     = v.ack;
    e.name = v.name;
    e.ctl  = v.ctl;
    sbq.push_back(e);
  endtask

  // One full cycle: drive, compare controls mid-cycle, then check the stall
  // counter just after the edge against the bench's own running count.
  task automatic cycle(input vec_t v);
    exp_t e;
    drive(v);
    @(negedge clk_i);
    e = sbq.pop_front();
    chk({e.name, " ctl"}, 32'(ctlNow()), 32'(e.ctl));
    if (!e.ctl[4]) expCnt++;
    @(posedge clk_i);
    #1;
    chk({e.name, " stall_cnt"}, bus.stall_cnt_o, expCnt);
  endtask

  initial begin
    drive(mk("rst_in", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_RUN));
    repeat (2) @(negedge clk_i);
    begin
      exp_t e;
      e = sbq.pop_front();
      chk("reset ctl", 32'(ctlNow()), 32'(e.ctl));
    end
    chk("reset stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("reset timeout", 32'(bus.timeout_o), 32'd0);
    chk("reset proto_err", 32'(bus.proto_err_o), 32'd0);
    void'(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    bus.EX_memRead_i = 1'b0; bus.MEM_memReq_i = 1'b0; bus.ID_branchTaken_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    //                 name        rs     rt     uRt   mRd   wb     br    req   ack   ctl
    tbl.push_back(mk("lu_rs",     5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU));
    tbl.push_back(mk("x0_load",   5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    tbl.push_back(mk("rt_unused", 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_RUN));
    tbl.push_back(mk("lu_rt",     5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU));
    tbl.push_back(mk("no_load",   5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_RUN));
    tbl.push_back(mk("branch",    5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_FLUSH));
    tbl.push_back(mk("lu_br",     5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_LU));
    tbl.push_back(mk("ms_lu_br",  5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_MS));
    tbl.push_back(mk("wait_ack",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN));
    tbl.push_back(mk("hit",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN));
    tbl.push_back(mk("run_idle",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    tbl.push_back(mk("hit_lu",    5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, C_LU));
    tbl.push_back(mk("after_hit", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    foreach (tbl[i]) cycle(tbl[i]);

    // Miss acked three cycles after the request: three stall cycles, then RUN.
    for (int i = 0; i < 3; i++)
      cycle(mk($sformatf("miss3_w%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    cycle(mk("miss3_ack", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN));
    cycle(mk("miss3_run", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));

    // Back-to-back: a new miss right after an ack is taken fresh from RUN.
    cycle(mk("b2b_m1",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    cycle(mk("b2b_ack1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN));
    cycle(mk("b2b_m2",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    cycle(mk("b2b_m2w",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    cycle(mk("b2b_ack2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN));
    cycle(mk("b2b_run",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    chk("no timeout yet", 32'(bus.timeout_o), 32'd0);
    chk("no proto_err yet", 32'(bus.proto_err_o), 32'd0);

    // Stray ack with no request: no stall, sticky protocol error.
    cycle(mk("stray_ack", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_RUN));
    chk("proto_err set", 32'(bus.proto_err_o), 32'd1);
    cycle(mk("stray_idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    chk("proto_err sticky", 32'(bus.proto_err_o), 32'd1);

    // Timeout with TIMEOUT_CYC=4: request cycle in RUN, then WAIT cycles 1..4.
    cycle(mk("to_req", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    for (int i = 1; i <= 3; i++)
      cycle(mk($sformatf("to_w%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    chk("timeout before 4th wait", 32'(bus.timeout_o), 32'd0);
    cycle(mk("to_w4", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    chk("timeout after 4th wait", 32'(bus.timeout_o), 32'd1);
    for (int i = 5; i <= 6; i++)
      cycle(mk($sformatf("to_w%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS));
    chk("timeout sticky", 32'(bus.timeout_o), 32'd1);

    // Reset mid-WAIT, with a load-use also present: outputs must snap back at once.
    bus.EX_memRead_i = 1'b1; bus.EX_wbAddr_i = 5'd4; bus.ID_rsAddr_i = 5'd4;
    #2;
    rst_i = 1'b0;
    #1;
    chk("midwait rst ctl", 32'(ctlNow()), 32'(C_RUN));
    chk("midwait rst stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("midwait rst timeout", 32'(bus.timeout_o), 32'd0);
    chk("midwait rst proto_err", 32'(bus.proto_err_o), 32'd0);
    expCnt = 32'd0;
    bus.EX_memRead_i = 1'b0; bus.MEM_memReq_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cycle(mk("post_rst_run", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN));
    cycle(mk("post_rst_lu",  5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_LU));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer-side counterpart of EX-stage operand forwarding. Decides when forwarding cannot resolve a hazard and the pipeline must stall, bubble or flush.
- Sits beside the ID stage of the 5-stage pipeline. Drives PC/IF-ID write enables, the ID/EX bubble, the IF/ID flush, and a global freeze for EX/MEM/WB.
- Handles three cases: load-use stalls, multi-cycle data-memory waits (req/ack handshake with a watchdog), and taken-branch flushes.
- Keeps a saturating stall-cycle counter.

Parameters:
- TIMEOUT_CYC, 64, number of WAIT-state cycles without ack before timeout_o sets.
- CNT_W, 32, width of stall_cnt_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- ID_rsAddr_i  in  5  rs of instruction in ID.
- ID_rtAddr_i  in  5  rt of instruction in ID.
- ID_useRt_i  in  1  ID instruction reads rt.
- EX_memRead_i  in  1  EX instruction is a load.
- EX_wbAddr_i  in  5  destination register of EX instruction.
- ID_branchTaken_i  in  1  branch in ID resolved taken.
- MEM_memReq_i  in  1  MEM stage data access in flight; held high until acked.
- MEM_memAck_i  in  1  single-cycle pulse: data memory completes access.
- PC_write_o  out  1  PC update enable.
- IFID_write_o  out  1  IF/ID register enable.
- IFID_flush_o  out  1  zero IF/ID on next edge.
- IDEX_bubble_o  out  1  load NOP control into ID/EX.
- pipe_stall_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  cycles with PC_write_o low, saturating.
- timeout_o  out  1  sticky: memory wait exceeded TIMEOUT_CYC.
- proto_err_o  out  1  sticky: ack seen without req.

Behaviour:
- Reset (rst_i low, async): state=RUN; wait counter, stall_cnt_o, timeout_o and proto_err_o all 0. While in reset: PC_write_o=1, IFID_write_o=1, IFID_flush_o=0, IDEX_bubble_o=0, pipe_stall_o=0.
- Hazard detects are combinational. Control outputs are Mealy (state + inputs) with zero-cycle latency, so a stall applies on the same cycle it is detected.
- Load-use detect lu = EX_memRead_i && EX_wbAddr_i!=0 && (EX_wbAddr_i==ID_rsAddr_i || (ID_useRt_i && EX_wbAddr_i==ID_rtAddr_i)).
- Memory stall ms = (state==RUN && MEM_memReq_i && !MEM_memAck_i) || (state==WAIT && !MEM_memAck_i).
- Output priority, ms > lu > branch:
  - ms: pipe_stall_o=1, PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=0, IFID_flush_o=0.
  - else lu: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IFID_flush_o=0 (branch retried next cycle).
  - else ID_branchTaken_i: IFID_flush_o=1, all writes enabled.
  - else: all writes enabled, no bubble or flush.
- FSM states RUN and WAIT:
  - RUN: req && !ack -> WAIT with wait counter cleared to 1. req && ack -> RUN (hit, no stall).
  - WAIT: ack -> RUN; stall drops in the ack cycle so the pipeline advances on that edge. !ack -> stay, wait counter +1 (saturates at TIMEOUT_CYC).
  - If the wait counter reaches TIMEOUT_CYC in WAIT: timeout_o sets and stays set until reset. FSM remains in WAIT and keeps stalling.
- Ack while MEM_memReq_i is low: ignored for FSM purposes, proto_err_o sets (sticky).
- A back-to-back request (new req the cycle after an ack) is evaluated fresh in RUN.
- stall_cnt_o: +1 on each edge where PC_write_o==0, saturates at all-ones, never wraps.
- Reset asserted mid-WAIT: immediate return to RUN, all outputs to reset values. Any in-flight access is abandoned.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum {RUN, WAIT}; constant REG_ZERO=5'd0; forward-select encodings (NONE=00, WB=01, MEM=10) for shared use.
- One sub-module: sat_counter (parameterised width, enable, saturate). Used for stall_cnt_o and the wait counter.

Test Plan:
- Reset then EX_memRead_i=1, EX_wbAddr_i=5, ID_rsAddr_i=5 for 1 cycle -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1 that cycle; stall_cnt_o=1 after the edge.
- EX_wbAddr_i=0 with a load and ID_rsAddr_i=0 -> no stall. EX_wbAddr_i=7, ID_rtAddr_i=7, ID_useRt_i=0 -> no stall.
- MEM_memReq_i=1 held, ack pulses 3 cycles later -> pipe_stall_o high for 3 cycles, low in the ack cycle; stall_cnt_o +3; state back to RUN.
- req and ack in the same cycle in RUN -> zero stall cycles, state stays RUN.
- Load-use plus ID_branchTaken_i together -> IDEX_bubble_o=1, IFID_flush_o=0. Same with ms active -> IDEX_bubble_o=0, pipe_stall_o=1.
- TIMEOUT_CYC=4, req held with no ack -> timeout_o=1 after the 4th WAIT cycle and stays high. Stray ack with req low -> proto_err_o=1. rst_i low mid-WAIT -> all outputs at reset values immediately.
